// File: rtl/multichannel_deadtime_generator.sv
// -----------------------------------------------------------------------------
// multichannel_deadtime_generator
//
// Complementary dead-time inserter for N_CHANNELS half-bridge legs. Each leg
// turns one PWM reference into high-side/low-side gate drives. Both switches
// are held off for a programmable number of cycles before either side turns
// on. A reference pulse shorter than the dead time is aborted cleanly, so the
// requested side never turns on. A latched fault forces every leg off, and a
// bypass mode (enable=0) drives the gates straight from the reference.
//
// Ports:
//   clock          system clock
//   reset          synchronous, active-low reset
//   enable         1 = dead-time insertion, 0 = bypass (debug only)
//   in_ref         PWM reference per channel (1 = high side requested)
//   dead_time_rise off cycles before the high side turns on
//   dead_time_fall off cycles before the low side turns on
//   fault          active-high fault request, sampled on clock
//   clear_fault    fault-latch clear request (ignored while fault=1)
//   out_h          high-side gates, decoded from the state register
//   out_l          low-side gates, decoded from the state register
//   fault_active   fault latch state
// -----------------------------------------------------------------------------
module multichannel_deadtime_generator #(
    parameter int unsigned N_CHANNELS    = 3,
    parameter int unsigned COUNTER_WIDTH = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     enable,
    input  logic [N_CHANNELS-1:0]    in_ref,
    input  logic [COUNTER_WIDTH-1:0] dead_time_rise,
    input  logic [COUNTER_WIDTH-1:0] dead_time_fall,
    input  logic                     fault,
    input  logic                     clear_fault,
    output logic [N_CHANNELS-1:0]    out_h,
    output logic [N_CHANNELS-1:0]    out_l,
    output logic                     fault_active
);

    typedef enum logic [2:0] {
        StOff    = 3'd0,
        StLowOn  = 3'd1,
        StDtRise = 3'd2,
        StHighOn = 3'd3,
        StDtFall = 3'd4
    } state_e;

    state_e                   state_q [N_CHANNELS];
    state_e                   state_d [N_CHANNELS];
    logic [COUNTER_WIDTH-1:0] cnt_q   [N_CHANNELS];
    logic [COUNTER_WIDTH-1:0] cnt_d   [N_CHANNELS];
    logic                     fault_latch_q;
    logic                     fault_latch_d;

    logic                     shutdown;
    logic                     rise_zero;
    logic                     fall_zero;
    logic [COUNTER_WIDTH-1:0] rise_load;
    logic [COUNTER_WIDTH-1:0] fall_load;

    // The counter counts down to zero inclusive, so loading value-1 gives a
    // dead interval of exactly the programmed number of cycles.
    assign rise_zero = (dead_time_rise == '0);
    assign fall_zero = (dead_time_fall == '0);
    assign rise_load = dead_time_rise - COUNTER_WIDTH'(1);
    assign fall_load = dead_time_fall - COUNTER_WIDTH'(1);

    // A fault seen at this edge takes effect at once, without waiting a cycle
    // for the latch.
    assign shutdown = fault_latch_q | fault;

    always_comb begin
        fault_latch_d = fault_latch_q;
        if (fault) begin
            fault_latch_d = 1'b1;
        end else if (clear_fault) begin
            fault_latch_d = 1'b0;
        end
    end

    always_comb begin
        for (int i = 0; i < N_CHANNELS; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];

            if (shutdown) begin
                state_d[i] = StOff;
                cnt_d[i]   = '0;
            end else if (!enable) begin
                state_d[i] = in_ref[i] ? StHighOn : StLowOn;
                cnt_d[i]   = '0;
            end else begin
                case (state_q[i])
                    // Leaving OFF always goes through a dead interval first.
                    StOff, StLowOn, StHighOn: begin
                        if (in_ref[i] && state_q[i] != StHighOn) begin
                            state_d[i] = rise_zero ? StHighOn : StDtRise;
                            cnt_d[i]   = rise_load;
                        end else if (!in_ref[i] && state_q[i] != StLowOn) begin
                            state_d[i] = fall_zero ? StLowOn : StDtFall;
                            cnt_d[i]   = fall_load;
                        end
                    end
                    StDtRise: begin
                        if (!in_ref[i]) begin
                            state_d[i] = StLowOn;
                        end else if (cnt_q[i] == '0) begin
                            state_d[i] = StHighOn;
                        end else begin
                            cnt_d[i] = cnt_q[i] - COUNTER_WIDTH'(1);
                        end
                    end
                    StDtFall: begin
                        if (in_ref[i]) begin
                            state_d[i] = StHighOn;
                        end else if (cnt_q[i] == '0) begin
                            state_d[i] = StLowOn;
                        end else begin
                            cnt_d[i] = cnt_q[i] - COUNTER_WIDTH'(1);
                        end
                    end
                    default: begin
                        state_d[i] = StOff;
                        cnt_d[i]   = '0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            fault_latch_q <= 1'b0;
            for (int i = 0; i < N_CHANNELS; i++) begin
                state_q[i] <= StOff;
                cnt_q[i]   <= '0;
            end
        end else begin
            fault_latch_q <= fault_latch_d;
            for (int i = 0; i < N_CHANNELS; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

    // Gates come from the state register only, so they cannot glitch.
    always_comb begin
        out_h = '0;
        out_l = '0;
        for (int i = 0; i < N_CHANNELS; i++) begin
            out_h[i] = (state_q[i] == StHighOn);
            out_l[i] = (state_q[i] == StLowOn);
        end
    end

    assign fault_active = fault_latch_q;

endmodule

// File: tb/tb_multichannel_deadtime_generator.sv
// -----------------------------------------------------------------------------
// tb_multichannel_deadtime_generator
//
// The reference model tracks, per leg, the side currently requested and the
// number of dead cycles still to run before that side may conduct. It is
// checked against the DUT after every clock edge, and a set of directed
// scenarios pins literal values on top of that.
// -----------------------------------------------------------------------------
module tb_multichannel_deadtime_generator;

    localparam int N = 3;
    localparam int W = 16;

    logic         clock = 1'b0;
    logic         reset;
    logic         enable;
    logic [N-1:0] in_ref;
    logic [W-1:0] dead_time_rise;
    logic [W-1:0] dead_time_fall;
    logic         fault;
    logic         clear_fault;
    logic [N-1:0] out_h;
    logic [N-1:0] out_l;
    logic         fault_active;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clock = ~clock;

    multichannel_deadtime_generator #(
        .N_CHANNELS    (N),
        .COUNTER_WIDTH (W)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .enable         (enable),
        .in_ref         (in_ref),
        .dead_time_rise (dead_time_rise),
        .dead_time_fall (dead_time_fall),
        .fault          (fault),
        .clear_fault    (clear_fault),
        .out_h          (out_h),
        .out_l          (out_l),
        .fault_active   (fault_active)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
        end
    endtask

    // Reference model: off = leg forced off; tgt = requested side;
    // rem = dead cycles still to elapse before tgt conducts.
    bit           m_off [N];
    bit           m_tgt [N];
    int           m_rem [N];
    bit           m_latch;
    bit           m_en;
    logic [N-1:0] exp_h;
    logic [N-1:0] exp_l;

    function automatic int dt_for(input bit side);
        return side ? int'(dead_time_rise) : int'(dead_time_fall);
    endfunction

    task automatic model_step();
        bit sd;
        m_en = enable;
        if (!reset) begin
            m_latch = 1'b0;
            for (int i = 0; i < N; i++) begin
                m_off[i] = 1'b1;
                m_rem[i] = 0;
            end
        end else begin
            sd = m_latch | fault;
            if (fault) m_latch = 1'b1;
            else if (clear_fault) m_latch = 1'b0;
            for (int i = 0; i < N; i++) begin
                if (sd) begin
                    m_off[i] = 1'b1;
                    m_rem[i] = 0;
                end else if (!enable) begin
                    m_off[i] = 1'b0;
                    m_tgt[i] = in_ref[i];
                    m_rem[i] = 0;
                end else if (m_off[i]) begin
                    m_off[i] = 1'b0;
                    m_tgt[i] = in_ref[i];
                    m_rem[i] = dt_for(in_ref[i]);
                end else if (m_tgt[i] != in_ref[i]) begin
                    // Reversal during a dead interval is an abort back to
                    // the side that was already conducting.
                    m_rem[i] = (m_rem[i] > 0) ? 0 : dt_for(in_ref[i]);
                    m_tgt[i] = in_ref[i];
                end else if (m_rem[i] > 0) begin
                    m_rem[i] = m_rem[i] - 1;
                end
            end
        end
        for (int i = 0; i < N; i++) begin
            exp_h[i] = !m_off[i] && m_tgt[i] && (m_rem[i] == 0);
            exp_l[i] = !m_off[i] && !m_tgt[i] && (m_rem[i] == 0);
        end
    endtask

    initial begin
        m_latch = 1'b0;
        m_en    = 1'b1;
        for (int i = 0; i < N; i++) begin
            m_off[i] = 1'b1;
            m_tgt[i] = 1'b0;
            m_rem[i] = 0;
        end
        forever begin
            @(posedge clock);
            model_step();
            #1;
            check("model", {fault_active, out_h, out_l}, {m_latch, exp_h, exp_l});
            if (m_en || m_latch) check("no_overlap", out_h & out_l, 0);
        end
    end

    // Inputs change 2 time units after each rising edge.
    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    logic [N-1:0] prev_ref;

    initial begin
        reset          = 1'b0;
        enable         = 1'b1;
        fault          = 1'b0;
        clear_fault    = 1'b0;
        in_ref         = '0;
        dead_time_rise = 16'd5;
        dead_time_fall = 16'd5;
        repeat (3) tick();
        check("reset_state", {fault_active, out_h, out_l}, 0);

        // Reset exit passes through a 5-cycle dead interval.
        reset = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            check("release_dead", {out_h, out_l}, 0);
        end
        tick();
        check("release_low", {out_h, out_l}, 6'b000_111);

        // Channel 0: rise with 5 dead cycles, fall with 3.
        dead_time_fall = 16'd3;
        in_ref = 3'b001;
        tick();
        check("rise_dead", {out_h[0], out_l[0]}, 2'b00);
        repeat (4) tick();
        check("rise_still_dead", {out_h[0], out_l[0]}, 2'b00);
        tick();
        check("rise_high_on", {out_h[0], out_l[0]}, 2'b10);
        in_ref = 3'b000;
        tick();
        check("fall_dead", {out_h[0], out_l[0]}, 2'b00);
        repeat (2) tick();
        check("fall_still_dead", {out_h[0], out_l[0]}, 2'b00);
        tick();
        check("fall_low_on", {out_h[0], out_l[0]}, 2'b01);

        // Channel 1: 2-cycle pulse is shorter than the rise dead time.
        in_ref = 3'b010;
        repeat (2) begin
            tick();
            check("short_pulse_dead", {out_h[1], out_l[1]}, 2'b00);
        end
        in_ref = 3'b000;
        tick();
        check("short_pulse_abort", {out_h[1], out_l[1]}, 2'b01);

        // Channel 2: zero rise dead time, then a short low pulse aborts.
        dead_time_rise = 16'd0;
        dead_time_fall = 16'd5;
        in_ref = 3'b100;
        tick();
        check("rise_zero_dt", {out_h[2], out_l[2]}, 2'b10);
        in_ref = 3'b000;
        repeat (2) begin
            tick();
            check("short_low_dead", {out_h[2], out_l[2]}, 2'b00);
        end
        in_ref = 3'b100;
        tick();
        check("short_low_abort", {out_h[2], out_l[2]}, 2'b10);

        // Zero rise / one-cycle fall on all channels.
        dead_time_fall = 16'd1;
        in_ref = 3'b000;
        repeat (3) tick();
        in_ref = 3'b111;
        tick();
        check("dt0_rise", {out_h, out_l}, 6'b111_000);
        in_ref = 3'b000;
        tick();
        check("dt1_fall_dead", {out_h, out_l}, 6'b000_000);
        tick();
        check("dt1_fall_low", {out_h, out_l}, 6'b000_111);

        // Fault while all legs conduct high.
        dead_time_rise = 16'd2;
        in_ref = 3'b111;
        repeat (3) tick();
        check("pre_fault_high", {out_h, out_l}, 6'b111_000);
        fault = 1'b1;
        tick();
        check("fault_off", {fault_active, out_h, out_l}, 7'b1_000_000);
        clear_fault = 1'b1;
        tick();
        check("clear_ignored", {fault_active, out_h, out_l}, 7'b1_000_000);
        fault = 1'b0;
        tick();
        check("clear_ok", {fault_active, out_h, out_l}, 7'b0_000_000);
        clear_fault = 1'b0;
        repeat (2) begin
            tick();
            check("fault_exit_dead", {out_h, out_l}, 6'b000_000);
        end
        tick();
        check("fault_exit_high", {out_h, out_l}, 6'b111_000);

        // Bypass: gates follow the reference with one cycle of latency.
        enable = 1'b0;
        for (int c = 0; c < 40; c++) begin
            in_ref   = 3'($urandom);
            prev_ref = in_ref;
            tick();
            check("bypass", {out_h, out_l}, {prev_ref, ~prev_ref});
        end

        // Randomised run against the model.
        enable = 1'b1;
        for (int c = 0; c < 2000; c++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 5) == 0) in_ref[i] = ~in_ref[i];
            end
            if ($urandom_range(0, 15) == 0) dead_time_rise = 16'($urandom_range(0, 6));
            if ($urandom_range(0, 15) == 0) dead_time_fall = 16'($urandom_range(0, 6));
            fault       = ($urandom_range(0, 79) == 0);
            clear_fault = ($urandom_range(0, 11) == 0);
            enable      = ($urandom_range(0, 59) != 0);
            reset       = ($urandom_range(0, 399) != 0);
            tick();
        end

        reset       = 1'b1;
        fault       = 1'b0;
        clear_fault = 1'b0;
        repeat (2) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/multichannel_deadtime_generator.md
Name: multichannel_deadtime_generator

Overview:
Parametrised complementary dead-time inserter for N half-bridge legs. Each channel takes one PWM reference and produces high-side and low-side gate signals. Separate programmable rising-edge and falling-edge dead times, clean abort of pulses shorter than the dead time, a latched fault shutdown, and a bypass mode. Sits between the PWM generator outputs and the gate-driver pins.

Parameters:
N_CHANNELS, 3, number of independent legs
COUNTER_WIDTH, 16, width of dead-time values and per-channel counters

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-low reset
enable  in  1  1 = dead-time insertion active; 0 = bypass
in_ref  in  N_CHANNELS  PWM reference per channel (1 = high side requested)
dead_time_rise  in  COUNTER_WIDTH  cycles both switches are off before the high side turns on
dead_time_fall  in  COUNTER_WIDTH  cycles both switches are off before the low side turns on
fault  in  1  active-high fault request, sampled on clock
clear_fault  in  1  single-cycle fault-latch clear request
out_h  out  N_CHANNELS  high-side gate, registered
out_l  out  N_CHANNELS  low-side gate, registered
fault_active  out  1  fault latch state

Behaviour:
- Single clock domain. Reset is synchronous and active-low, sampled on the rising edge of clock.
- Reset:
  - All channel FSMs go to OFF.
  - fault_latch=0.
  - out_h=0, out_l=0, fault_active=0.
- Fault latch:
  - Set on any edge where fault=1.
  - Cleared on an edge where clear_fault=1 and fault=0.
  - If fault and clear_fault are both 1, the latch stays set.
  - fault_active equals the latch register.
- Per-channel FSM, one counter per channel. State outputs (h,l):
  - OFF (0,0)
  - LOW_ON (0,1)
  - DT_RISE (0,0)
  - HIGH_ON (1,0)
  - DT_FALL (0,0)
- Priority of conditions, highest first:
  - fault_latch set, or fault=1 at the edge: go to OFF. Overrides enable and everything else.
  - enable=0 (bypass): state follows in_ref directly, HIGH_ON if in_ref=1 else LOW_ON. No dead time is inserted; this is a debug mode only.
  - Normal transitions below.
- Normal transitions:
  - OFF, latch clear: go to DT_RISE if in_ref=1, else DT_FALL, loading the corresponding dead time. A zero dead time goes straight to HIGH_ON/LOW_ON. Both reset exit and fault exit therefore pass through a dead interval.
  - LOW_ON, in_ref=1: if dead_time_rise=0 go to HIGH_ON; else go to DT_RISE with counter=dead_time_rise-1.
  - DT_RISE, in_ref=0: abort to LOW_ON immediately. The high side never turns on.
  - DT_RISE, counter=0: go to HIGH_ON. Otherwise decrement the counter.
  - HIGH_ON, in_ref=0: if dead_time_fall=0 go to LOW_ON; else go to DT_FALL with counter=dead_time_fall-1.
  - DT_FALL, in_ref=1: abort to HIGH_ON.
  - DT_FALL, counter=0: go to LOW_ON. Otherwise decrement the counter.
- Timing:
  - Dead interval is exactly the programmed value in cycles.
  - Input-to-output latency is 1 cycle. A change of in_ref sampled at edge k updates the state at edge k.
  - out_h/out_l are decoded from the state register only, so the outputs are glitch-free.
- Dead-time values are captured only at counter load. Changes mid-interval affect the next interval only.
- Invariant: out_h & out_l = 0 whenever enable=1 or fault_latch=1.
- Channels are fully independent apart from the shared fault, enable and dead-time inputs.
- Unknown or illegal state: go to OFF.

Test Plan:
- Reset, then release with dead_time_rise=dead_time_fall=5 and in_ref=0 → out_h=out_l=0 for 5 cycles after release, then out_l=1.
- in_ref[0] rises at edge k, dead_time_rise=5 → out_l[0]=0 from k, out_h[0]=1 from k+5; in_ref[0] falls with dead_time_fall=3 → out_h drops, out_l=1 three cycles later.
- in_ref high for 2 cycles with dead_time_rise=5 → out_h never asserts, out_l returns to 1 after 2 cycles; repeat the mirror case for DT_FALL.
- dead_time_rise=0, dead_time_fall=1 → rising edge gives out_h=1 with 1-cycle latency; falling edge gives exactly 1 cycle of (0,0).
- fault pulse while channels are in HIGH_ON → all outputs 0 next cycle, fault_active=1. clear_fault while fault=1 is ignored. clear_fault with fault=0 → dead interval, then the state follows in_ref.
- enable=0, random in_ref → out_h=in_ref, out_l=~in_ref at 1-cycle latency. Throughout all enable=1 runs, assert out_h&out_l==0 every cycle on all 3 channels.
